psc_top: RTL and testbench

- Register-mapped core of a power-supply controller (PSC).
- Accepts 32-bit writes/reads from a PS-side bus bridge (AXI-lite already decoded to a simple strobe bus, base 0x43C00000 stripped).
- Drives front-panel LEDs, a DAC setpoint in jump or ramp-table (smooth) mode, and per-channel DCCT offset/gain calibration.
- Sits between the processor bridge and the DAC/ADC serial engines.

---
 rtl/psc_top.sv | 227 ++++++++++++++++++++++
 tb/tb_psc_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/psc_top.sv
// Power-supply controller register core: LEDs, DAC setpoint (jump or ramp table) and DCCT calibration.
// Optional macro RAMP_READBACK_EN enables reading ramp memory back at 0x120.
`timescale 1ns/1ps
module psc_top #(
    parameter int FPGA_VERSION = 1,
    parameter int SIM_MODE     = 0,
    parameter int RAMP_DIV     = 10000,
    parameter int RAMP_AW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] reg_addr,
    input  logic        reg_wr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_rd,
    output logic [31:0] reg_rdata,
    input  logic [71:0] dcct_adc,
    output logic [79:0] dcct_cal,
    output logic [7:0]  fp_leds,
    output logic [19:0] dac_setpt,
    output logic        dac_update,
    output logic        ramp_active
);

    localparam int          DEPTH     = 1 << RAMP_AW;
    localparam int          TICK_N    = (SIM_MODE != 0) ? 4 : RAMP_DIV;
    localparam logic [31:0] TICK_LAST = 32'(TICK_N - 1);
    localparam logic [RAMP_AW:0] LEN_MAX = DEPTH[RAMP_AW:0];

    logic [7:0]         leds_reg;
    logic [19:0]        setpoint_reg;
    logic [1:0]         opmode_reg;
    logic [RAMP_AW:0]   ramplen_reg;
    logic [RAMP_AW-1:0] rampaddr_reg;
    logic [RAMP_AW:0]   idx_reg;
    logic [31:0]        div_cnt_reg;
    logic               active_reg;
    logic               done_reg;
    logic [19:0]        dac_reg;
    logic               update_reg;
    logic [31:0]        rdata_reg;
    logic [17:0]        offset_reg [4];
    logic [15:0]        gain_reg [4];

    logic [19:0] ram [DEPTH];
    logic [19:0] ram_q;

    logic wr_leds, wr_setpt, wr_mode, wr_len, wr_raddr, wr_rdata, wr_ctrl, wr_dcct;
    logic tick, step, last_step, abort, jump_entry, start_ok;

    always_comb begin
        wr_leds    = reg_wr && (reg_addr == 12'h004);
        wr_setpt   = reg_wr && (reg_addr == 12'h108);
        wr_mode    = reg_wr && (reg_addr == 12'h10C);
        wr_len     = reg_wr && (reg_addr == 12'h118);
        wr_raddr   = reg_wr && (reg_addr == 12'h11C);
        wr_rdata   = reg_wr && (reg_addr == 12'h120);
        wr_ctrl    = reg_wr && (reg_addr == 12'h124);
        wr_dcct    = reg_wr && (reg_addr[11:8] == 4'h4) && (reg_addr[5:0] == 6'h00 || reg_addr[5:0] == 6'h04);
        tick       = (div_cnt_reg == TICK_LAST);
        step       = tick && active_reg;
        last_step  = (idx_reg + 1'b1) >= ramplen_reg;
        abort      = wr_mode && active_reg && (reg_wdata[1:0] != opmode_reg);
        jump_entry = wr_mode && (reg_wdata[1:0] == 2'd3) && (opmode_reg != 2'd3);
        start_ok   = wr_ctrl && reg_wdata[0] && (opmode_reg == 2'd0) && (ramplen_reg != '0);
    end

    // Ramp memory: write port on the bus, registered read feeding the step logic.
    always_ff @(posedge clk) begin
        if (wr_rdata)
            ram[rampaddr_reg] <= reg_wdata[19:0];
        ram_q <= ram[idx_reg[RAMP_AW-1:0]];
    end

`ifdef RAMP_READBACK_EN
    // Prefetch the word at the address rampaddr will hold after this edge (write-first),
    // so a bus read can return it from a register with no added latency.
    logic [RAMP_AW-1:0] rampaddr_next;
    logic [19:0]        rb_q;
    assign rampaddr_next = wr_raddr ? reg_wdata[RAMP_AW-1:0] : rampaddr_reg;
    always_ff @(posedge clk) begin
        if (wr_rdata)
            rb_q <= reg_wdata[19:0];
        else
            rb_q <= ram[rampaddr_next];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_reg     <= '0;
            setpoint_reg <= '0;
            opmode_reg   <= '0;
            ramplen_reg  <= '0;
            rampaddr_reg <= '0;
            idx_reg      <= '0;
            div_cnt_reg  <= '0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
            dac_reg      <= '0;
            update_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                offset_reg[i] <= '0;
                gain_reg[i]   <= '0;
            end
        end else begin
            update_reg  <= 1'b0;
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
            if (wr_leds)
                leds_reg <= reg_wdata[7:0];
            if (wr_setpt) begin
                setpoint_reg <= reg_wdata[19:0];
                if (opmode_reg == 2'd3) begin
                    dac_reg    <= reg_wdata[19:0];
                    update_reg <= 1'b1;
                end
            end
            if (wr_mode) begin
                opmode_reg <= reg_wdata[1:0];
                if (jump_entry) begin
                    dac_reg    <= setpoint_reg;
                    update_reg <= 1'b1;
                end
            end
            if (wr_len)
                ramplen_reg <= (reg_wdata > 32'(DEPTH)) ? LEN_MAX : reg_wdata[RAMP_AW:0];
            if (wr_raddr)
                rampaddr_reg <= reg_wdata[RAMP_AW-1:0];
            if (wr_dcct) begin
                if (reg_addr[2])
                    gain_reg[reg_addr[7:6]] <= reg_wdata[15:0];
                else
                    offset_reg[reg_addr[7:6]] <= reg_wdata[17:0];
            end
            // A ramp step outranks any bus-driven DAC load in the same cycle.
            if (step) begin
                dac_reg    <= ram_q;
                update_reg <= 1'b1;
                if (last_step) begin
                    active_reg <= 1'b0;
                    done_reg   <= !abort;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            if (abort)
                active_reg <= 1'b0;
            if (start_ok) begin
                active_reg  <= 1'b1;
                done_reg    <= 1'b0;
                idx_reg     <= '0;
                div_cnt_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (reg_rd) begin
            rdata_reg <= '0;
            if (reg_addr[11:8] == 4'h4) begin
                if (reg_addr[5:0] == 6'h00)
                    rdata_reg <= {14'd0, offset_reg[reg_addr[7:6]]};
                else if (reg_addr[5:0] == 6'h04)
                    rdata_reg <= {16'd0, gain_reg[reg_addr[7:6]]};
            end else begin
                case (reg_addr)
                    12'h000: rdata_reg <= 32'(FPGA_VERSION);
                    12'h004: rdata_reg <= {24'd0, leds_reg};
                    12'h108: rdata_reg <= {12'd0, setpoint_reg};
                    12'h10C: rdata_reg <= {30'd0, opmode_reg};
                    12'h118: rdata_reg <= 32'(ramplen_reg);
                    12'h11C: rdata_reg <= 32'(rampaddr_reg);
`ifdef RAMP_READBACK_EN
                    12'h120: rdata_reg <= {12'd0, rb_q};
`endif
                    12'h124: rdata_reg <= {30'd0, done_reg, active_reg};
                    default: rdata_reg <= '0;
                endcase
            end
        end
    end

    // Calibration: 19-bit difference times unsigned Q1.15 gain, arithmetic shift, saturate to 20 bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cal
            logic signed [17:0] adc_s;
            logic signed [18:0] diff;
            logic signed [16:0] gain_s;
            logic signed [35:0] prod;
            logic signed [35:0] shf;
            logic [19:0]        sat;
            logic [19:0]        cal_reg;

            always_comb begin
                adc_s  = dcct_adc[18*gi +: 18];
                diff   = {adc_s[17], adc_s} - {offset_reg[gi][17], offset_reg[gi]};
                gain_s = {1'b0, gain_reg[gi]};
                prod   = diff * gain_s;
                shf    = prod >>> 15;
                if (shf > 36'sd524287)
                    sat = 20'h7FFFF;
                else if (shf < -36'sd524288)
                    sat = 20'h80000;
                else
                    sat = shf[19:0];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cal_reg <= '0;
                else
                    cal_reg <= sat;
            end

            assign dcct_cal[20*gi +: 20] = cal_reg;
        end
    endgenerate

    assign reg_rdata   = rdata_reg;
    assign fp_leds     = leds_reg;
    assign dac_setpt   = dac_reg;
    assign dac_update  = update_reg;
    assign ramp_active = active_reg;

endmodule

// File: tb/tb_psc_top.sv
// Directed bench for psc_top with the short simulation ramp divider (4 clocks per step).
`timescale 1ns/1ps
module tb_psc_top;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] reg_addr = '0;
    logic        reg_wr = 1'b0;
    logic [31:0] reg_wdata = '0;
    logic        reg_rd = 1'b0;
    logic [31:0] reg_rdata;
    logic [71:0] dcct_adc = '0;
    logic [79:0] dcct_cal;
    logic [7:0]  fp_leds;
    logic [19:0] dac_setpt;
    logic        dac_update;
    logic        ramp_active;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;
    int u0;
    logic [31:0] rv;

    psc_top #(.FPGA_VERSION(1), .SIM_MODE(1), .RAMP_DIV(10000), .RAMP_AW(8)) dut (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .dcct_adc(dcct_adc), .dcct_cal(dcct_cal),
        .fp_leds(fp_leds), .dac_setpt(dac_setpt), .dac_update(dac_update), .ramp_active(ramp_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dac_update === 1'b1) upd_cnt++;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0;
        $display("[TB] wr 0x%03h <= 0x%08h", a, d);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_addr = a; reg_rd = 1'b1;
        @(negedge clk);
        reg_rd = 1'b0;
        d = reg_rdata;
        $display("[TB] rd 0x%03h -> 0x%08h", a, d);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_dac", 80'(dac_setpt), 80'h0);
        check("rst_leds", 80'(fp_leds), 80'h0);
        check("rst_active", 80'(ramp_active), 80'h0);
        check("rst_rdata", 80'(reg_rdata), 80'h0);
        @(negedge clk); reset = 1'b0;

        // LEDs and version
        wr(12'h004, 32'h1); check("leds1", 80'(fp_leds), 80'h01);
        wr(12'h004, 32'h2); check("leds2", 80'(fp_leds), 80'h02);
        wr(12'h004, 32'h3); check("leds3", 80'(fp_leds), 80'h03);
        rd(12'h000, rv);    check("version", 80'(rv), 80'h1);
        rd(12'h200, rv);    check("unmapped", 80'(rv), 80'h0);

        // DCCT calibration
        wr(12'h400, 32'h20); wr(12'h404, 32'h7FFF);
        wr(12'h4C0, 32'h20); wr(12'h4C4, 32'h1234);
        dcct_adc[17:0]  = 18'h01020;
        dcct_adc[71:54] = 18'h01020;
        repeat (2) @(negedge clk);
        check("cal0", 80'(dcct_cal[19:0]), 80'h00FFF);
        check("cal3", 80'(dcct_cal[79:60]), 80'h00246);
        check("cal1_zero_gain", 80'(dcct_cal[39:20]), 80'h0);
        dcct_adc[17:0] = 18'h20000;
        repeat (2) @(negedge clk);
        check("cal0_neg", 80'(dcct_cal[19:0]), 80'hDFFE4);
        rd(12'h400, rv); check("offset_rb", 80'(rv), 80'h20);

        // Smooth mode: setpoint write stored, not output
        u0 = upd_cnt;
        wr(12'h108, 32'h555);
        repeat (2) @(negedge clk);
        check("smooth_setpt_hold", 80'(dac_setpt), 80'h0);
        check("smooth_setpt_noupd", 80'(upd_cnt - u0), 80'h0);

        // Jump mode
        u0 = upd_cnt;
        wr(12'h10C, 32'h3);
        check("jump_entry", 80'(dac_setpt), 80'h555);
        wr(12'h108, 32'h1234);
        check("jump_w1", 80'(dac_setpt), 80'h1234);
        check("jump_w1_pulse", 80'(dac_update), 80'h1);
        wr(12'h108, 32'h1000);
        check("jump_w2", 80'(dac_setpt), 80'h1000);
        @(negedge clk);
        check("jump_pulses", 80'(upd_cnt - u0), 80'h3);

        // Ramp table: mem[i] = i + 10
        for (int i = 0; i <= 20; i++) begin
            wr(12'h11C, 32'(i));
            wr(12'h120, 32'(i + 10));
        end
        wr(12'h10C, 32'h0);
        wr(12'h118, 32'd10);
        u0 = upd_cnt;
        wr(12'h124, 32'h1);
        check("ramp_start_active", 80'(ramp_active), 80'h1);
        for (int k = 0; k < 10; k++) begin
            repeat (4) @(negedge clk);
            check($sformatf("ramp_step%0d", k), 80'(dac_setpt), 80'(10 + k));
            check($sformatf("ramp_pulse%0d", k), 80'(dac_update), 80'h1);
        end
        check("ramp_end_active", 80'(ramp_active), 80'h0);
        repeat (8) @(negedge clk);
        check("ramp_hold", 80'(dac_setpt), 80'd19);
        check("ramp_pulses", 80'(upd_cnt - u0), 80'd10);
        rd(12'h124, rv); check("ramp_done", 80'(rv), 80'h2);

        // Abort by entering jump mode at step 3
        wr(12'h124, 32'h1);
        repeat (16) @(negedge clk);
        check("abort_pre", 80'(dac_setpt), 80'd13);
        wr(12'h10C, 32'h3);
        check("abort_dac", 80'(dac_setpt), 80'h1000);
        check("abort_pulse", 80'(dac_update), 80'h1);
        check("abort_inactive", 80'(ramp_active), 80'h0);
        rd(12'h124, rv); check("abort_status", 80'(rv), 80'h0);
        wr(12'h10C, 32'h0);
        wr(12'h124, 32'h1);
        repeat (4) @(negedge clk);
        check("restart_first", 80'(dac_setpt), 80'd10);

        // Starts that must be ignored: hold mode, zero length
        wr(12'h10C, 32'h1);
        wr(12'h124, 32'h1);
        repeat (2) @(negedge clk);
        check("hold_start_ignored", 80'(ramp_active), 80'h0);
        wr(12'h10C, 32'h0);
        wr(12'h118, 32'h0);
        u0 = upd_cnt;
        wr(12'h124, 32'h1);
        repeat (12) @(negedge clk);
        check("len0_active", 80'(ramp_active), 80'h0);
        check("len0_noupd", 80'(upd_cnt - u0), 80'h0);

        // Length clamp
        wr(12'h118, 32'd300);
        rd(12'h118, rv); check("len_clamp", 80'(rv), 80'h100);

        // Ramp memory readback
        wr(12'h11C, 32'd5);
        rd(12'h120, rv);
`ifdef RAMP_READBACK_EN
        check("mem_readback", 80'(rv), 80'd15);
`else
        check("mem_readback", 80'(rv), 80'h0);
`endif

        // Reset mid-ramp
        wr(12'h118, 32'd10);
        wr(12'h124, 32'h1);
        repeat (6) @(negedge clk);
        check("pre_reset_active", 80'(ramp_active), 80'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_dac", 80'(dac_setpt), 80'h0);
        check("arst_active", 80'(ramp_active), 80'h0);
        check("arst_leds", 80'(fp_leds), 80'h0);
        check("arst_cal", dcct_cal, 80'h0);
        check("arst_rdata", 80'(reg_rdata), 80'h0);
        @(negedge clk); reset = 1'b0;
        rd(12'h10C, rv); check("post_rst_opmode", 80'(rv), 80'h0);
        rd(12'h108, rv); check("post_rst_setpt", 80'(rv), 80'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
